flags_ctrl: RTL and testbench
=============================

// Module: flags_ctrl
// PURPOSE
//  Sequencer for the matmul over/underflow flags register (MAX_DIM^2 bits, one per result cell).
//  Per matmul run it clears or keeps the register, captures the per-cell flag vector on matmul completion,
//  then scans the stored bits to produce a summary: any-flag, flag count and lowest flagged cell index.
//  Sits between the matmul core and the flags register; the summary feeds the bus-side status registers.
// PARAMETERS
//  DATA_WIDTH  32                       element width
//  BUS_WIDTH   64                       bus width
//  MAX_DIM     BUS_WIDTH/DATA_WIDTH     max matrix dimension; N = MAX_DIM*MAX_DIM flag bits
//  (derived)   CNT_W = $clog2(N+1), IDX_W = max(1,$clog2(N))
// PORTS
//  clk_i          in   1      clock, all state on posedge
//  rst_ni         in   1      reset, asynchronous, active-low
//  start_i        in   1      start a run (sampled in IDLE only)
//  accum_i        in   1      sampled with start_i: 1 = OR new flags into stored flags, 0 = clear first
//  matmul_done_i  in   1      matmul result/flags valid (observed in RUN only)
//  ovf_vec_i      in   N      per-cell flag vector from matmul, valid with matmul_done_i
//  flags_we_o     out  1      write enable to flags register
//  flags_wdata_o  out  N      write data to flags register
//  flags_rdata_i  in   N      flags register read data (reads 0 while its write enable is high)
//  busy_o         out  1      high in every state except IDLE
//  done_o         out  1      one-cycle pulse, summary outputs valid and held until next start
//  ovf_any_o      out  1      at least one stored flag set
//  ovf_cnt_o      out  CNT_W  number of stored flags set
//  first_idx_o    out  IDX_W  lowest set bit index; 0 when none set
//  irq_o          out  1      interrupt (see CONFIGURATION)
//  irq_clr_i      in   1      interrupt clear
// BEHAVIOUR
//  - Reset: state IDLE; flags_we_o=0, flags_wdata_o=0, busy_o=0, done_o=0, ovf_any_o=0, ovf_cnt_o=0,
//    first_idx_o=0, irq_o=0. Reset mid-run aborts immediately; no write issued afterwards.
//  - FSM: IDLE -> (start_i & !accum_i) CLEAR | (start_i & accum_i) RUN
//    CLEAR (1 cyc): flags_we_o=1, flags_wdata_o=0 -> RUN
//    RUN: wait; matmul_done_i -> CAPTURE (ovf_vec_i registered that cycle)
//    CAPTURE (1 cyc): flags_we_o=1, wdata = accum ? (flags_rdata_i | vec) : vec -> SETTLE
//      flags_rdata_i is sampled in RUN on the matmul_done_i cycle (we low), never in CAPTURE.
//    SETTLE (1 cyc): we=0, wait for register output -> SCAN; scan index cleared, cnt cleared
//    SCAN (N cyc): bit i=0..N-1 of flags_rdata_i per cycle; cnt+=bit; first_idx latched on first set bit
//    DONE (1 cyc): done_o=1, ovf_any_o=(cnt!=0) -> IDLE
//  - flags_we_o high only in CLEAR/CAPTURE; flags_wdata_o=0 whenever we=0.
//  - Latency: done_o exactly N+3 cycles after the cycle matmul_done_i is sampled in RUN.
//  - Summary outputs are cleared on accepted start and updated only in SCAN/DONE.
//  - start_i while busy_o=1: ignored. matmul_done_i outside RUN: ignored, incl. same cycle as start.
//  - matmul_done_i held high several cycles: only first in RUN counts.
//  - ovf_cnt_o saturates at N by construction (CNT_W holds N); all-ones vector gives cnt=N, first_idx=0.
// CONFIGURATION
//  FLAGS_CTRL_IRQ_EN defined: irq_o sets in DONE when ovf_any; held until irq_clr_i (clear wins over set
//    in same cycle); not cleared by start.
//  Not defined: irq_o tied 0, irq_clr_i unused, no irq flop.
// STRUCTURE
//  Shared package: state enum (IDLE,CLEAR,RUN,CAPTURE,SETTLE,SCAN,DONE), N/CNT_W/IDX_W derivation.
//  Single module; optional sub-module flags_scan (bit-serial count + first-index) instantiated in SCAN.
// TESTING (MAX_DIM=2, N=4)
//  1. rst_ni low mid-SCAN -> all outputs 0, state IDLE, no further flags_we_o.
//  2. start accum=0, done vec=4'b0000 -> CLEAR write 0, CAPTURE write 0, cnt=0, any=0, idx=0.
//  3. start accum=0, done vec=4'b1010 -> wdata=1010, cnt=2, first_idx=1, any=1; done_o at +7 cycles.
//  4. stored 1010, start accum=1, vec=4'b0101 -> no CLEAR, wdata=1111, cnt=4, first_idx=0.
//  5. start_i in RUN and matmul_done_i in IDLE -> both ignored; single done_o per run.
//  6. FLAGS_CTRL_IRQ_EN: run of test 3 -> irq_o=1 until irq_clr_i; vec=0 run -> irq_o stays 0;
//     macro undefined -> irq_o always 0.

Source files
------------

// File: rtl/flags_ctrl_pkg.sv
// Shared types and derived sizes for the matmul flags sequencer.
package flags_ctrl_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned BUS_WIDTH  = 64;
   localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
   localparam int unsigned N          = MAX_DIM * MAX_DIM;
   // CNT_W must hold the value N itself, so the count can never wrap.
   localparam int unsigned CNT_W      = $clog2(N + 1);
   localparam int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StCapture,
      StSettle,
      StScan,
      StDone
   } state_e;

endpackage

// File: rtl/flags_scan.sv
// Bit-serial scanner: one stored flag bit per enabled cycle, accumulating the
// set-bit count and latching the index of the lowest set bit.
module flags_scan
   import flags_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [N-1:0]     rdata_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [IDX_W-1:0] first_idx_o,
   output logic             last_o
);

   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] first_q;
   logic             found_q;
   logic             bit_s;

   assign bit_s       = rdata_i[idx_q];
   assign last_o      = (idx_q == IDX_W'(N - 1));
   assign cnt_o       = cnt_q;
   assign first_idx_o = first_q;

   // Scan position, running count and first-set-bit capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         first_q <= '0;
         found_q <= 1'b0;
      end else if (clear_i) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         first_q <= '0;
         found_q <= 1'b0;
      end else if (en_i) begin
         idx_q <= last_o ? '0 : idx_q + IDX_W'(1);
         cnt_q <= cnt_q + CNT_W'(bit_s);
         if (bit_s && !found_q) begin
            found_q <= 1'b1;
            first_q <= idx_q;
         end
      end
   end

endmodule

// File: rtl/flags_ctrl.sv
// Matmul over/underflow flags sequencer: clears or keeps the flags register,
// captures the per-cell flag vector on matmul completion, then scans it into
// an any/count/first-index summary.
// Optional interrupt output enabled by defining FLAGS_CTRL_IRQ_EN.
module flags_ctrl
   import flags_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             accum_i,
   input  logic             matmul_done_i,
   input  logic [N-1:0]     ovf_vec_i,
   output logic             flags_we_o,
   output logic [N-1:0]     flags_wdata_o,
   input  logic [N-1:0]     flags_rdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_any_o,
   output logic [CNT_W-1:0] ovf_cnt_o,
   output logic [IDX_W-1:0] first_idx_o,
   output logic             irq_o,
   input  logic             irq_clr_i
);

   state_e           state_q, state_d;
   logic             accum_q;
   logic [N-1:0]     cap_q;
   logic             start_acc;
   logic             scan_last;
   logic [CNT_W-1:0] scan_cnt;

   assign start_acc = (state_q == StIdle) && start_i;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start_i) state_d = accum_i ? StRun : StClear;
         StClear:   state_d = StRun;
         StRun:     if (matmul_done_i) state_d = StCapture;
         StCapture: state_d = StSettle;
         StSettle:  state_d = StScan;
         StScan:    if (scan_last) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Accumulate mode and the merged write data; register read data is taken in RUN
   // because the register reads back 0 during the CAPTURE write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         accum_q <= 1'b0;
         cap_q   <= '0;
      end else begin
         if (start_acc) accum_q <= accum_i;
         if ((state_q == StRun) && matmul_done_i) begin
            cap_q <= accum_q ? (flags_rdata_i | ovf_vec_i) : ovf_vec_i;
         end
      end
   end

   // Flags register write port.
   always_comb begin
      flags_we_o    = 1'b0;
      flags_wdata_o = '0;
      if (state_q == StClear) begin
         flags_we_o = 1'b1;
      end else if (state_q == StCapture) begin
         flags_we_o    = 1'b1;
         flags_wdata_o = cap_q;
      end
   end

   flags_scan u_scan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (start_acc || (state_q == StSettle)),
      .en_i        (state_q == StScan),
      .rdata_i     (flags_rdata_i),
      .cnt_o       (scan_cnt),
      .first_idx_o (first_idx_o),
      .last_o      (scan_last)
   );

   assign busy_o    = (state_q != StIdle);
   assign done_o    = (state_q == StDone);
   assign ovf_cnt_o = scan_cnt;
   assign ovf_any_o = (scan_cnt != '0);

`ifdef FLAGS_CTRL_IRQ_EN
   logic irq_q;

   // Sticky interrupt; clear has priority over a same-cycle set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                             irq_q <= 1'b0;
      else if (irq_clr_i)                      irq_q <= 1'b0;
      else if ((state_q == StDone) && ovf_any_o) irq_q <= 1'b1;
   end

   assign irq_o = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr_i;
   assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_flags_ctrl.sv
// Self-checking bench for flags_ctrl with a behavioural flags register and a
// scoreboard of expected run summaries.
module tb_flags_ctrl;
   import flags_ctrl_pkg::*;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             start_i = 1'b0;
   logic             accum_i = 1'b0;
   logic             matmul_done_i = 1'b0;
   logic [N-1:0]     ovf_vec_i = '0;
   logic             flags_we_o;
   logic [N-1:0]     flags_wdata_o;
   logic [N-1:0]     flags_rdata_i;
   logic             busy_o, done_o, ovf_any_o, irq_o;
   logic [CNT_W-1:0] ovf_cnt_o;
   logic [IDX_W-1:0] first_idx_o;
   logic             irq_clr_i = 1'b0;

   flags_ctrl dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .accum_i       (accum_i),
      .matmul_done_i (matmul_done_i),
      .ovf_vec_i     (ovf_vec_i),
      .flags_we_o    (flags_we_o),
      .flags_wdata_o (flags_wdata_o),
      .flags_rdata_i (flags_rdata_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .ovf_any_o     (ovf_any_o),
      .ovf_cnt_o     (ovf_cnt_o),
      .first_idx_o   (first_idx_o),
      .irq_o         (irq_o),
      .irq_clr_i     (irq_clr_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [N-1:0]     wdata;
      logic [CNT_W-1:0] cnt;
      logic [IDX_W-1:0] idx;
      logic             any;
   } exp_t;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic [IDX_W-1:0] idx;
      logic             any;
      logic [7:0]       lat;
      logic             done_next;
      logic             cleared;
      logic             irq;
   } obs_t;

   int           vec_n = 0;
   int           miss_n = 0;
   int           done_cnt = 0;
   logic [N-1:0] reg_q = '0;
   logic [N-1:0] model_flags = '0;
   logic [N-1:0] wr_q[$];
   exp_t         sb[$];

   // Flags register: reads 0 while being written.
   assign flags_rdata_i = flags_we_o ? '0 : reg_q;

   always @(posedge clk_i) begin
      if (flags_we_o) begin
         reg_q <= flags_wdata_o;
         wr_q.push_back(flags_wdata_o);
      end
      if (done_o) done_cnt <= done_cnt + 1;
   end

   always @(negedge clk_i) begin
      if (rst_ni) begin
         vec_n++;
         if (!flags_we_o && flags_wdata_o !== '0) begin
            miss_n++;
            $display("FAIL wdata_idle: got %b, need 0", flags_wdata_o);
         end
      end
   end

   function automatic exp_t predict(input logic a, input logic [N-1:0] v);
      exp_t e;
      bit   found;
      e.wdata = a ? (model_flags | v) : v;
      e.cnt   = '0;
      e.idx   = '0;
      found   = 0;
      for (int i = 0; i < N; i++) begin
         if (e.wdata[i]) begin
            e.cnt = e.cnt + CNT_W'(1);
            if (!found) begin
               e.idx = IDX_W'(i);
               found = 1;
            end
         end
      end
      e.any = (e.cnt != '0);
      return e;
   endfunction

   // Drives one complete run and records what the DUT produced.
   task automatic do_run(input logic a, input logic [N-1:0] v, input int hold,
                         input bit inject, output obs_t o);
      int lat;
      wr_q.delete();
      @(posedge clk_i); #1;
      start_i = 1'b1; accum_i = a;
      @(posedge clk_i); #1;
      start_i = 1'b0; accum_i = 1'b0;
      o.cleared = (ovf_cnt_o == '0) && (first_idx_o == '0) && !ovf_any_o && busy_o;
      if (inject) begin
         start_i = 1'b1; accum_i = ~a;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0; accum_i = 1'b0;
      matmul_done_i = 1'b1; ovf_vec_i = v;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
         if (lat >= hold) matmul_done_i = 1'b0;
         if (done_o) break;
      end
      if (!done_o) $display("FAIL done_timeout: no done_o within %0d cycles", lat);
      matmul_done_i = 1'b0; ovf_vec_i = '0;
      o.cnt = ovf_cnt_o; o.idx = first_idx_o; o.any = ovf_any_o; o.irq = irq_o;
      o.lat = 8'(lat);
      @(posedge clk_i); #1;
      o.done_next = done_o;
   endtask

   task automatic test_reset;
      logic [N+CNT_W+IDX_W+5:0] got;
      int                       dc;
      #12;
      got = {flags_we_o, flags_wdata_o, busy_o, done_o, ovf_any_o, ovf_cnt_o, first_idx_o, irq_o};
      vec_n++;
      if (got !== '0) begin
         miss_n++; $display("FAIL reset_state: got %h, need 0", got);
      end
      @(posedge clk_i); #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      @(posedge clk_i); #1;
      matmul_done_i = 1'b1; ovf_vec_i = 4'b1010;
      @(posedge clk_i); #1 matmul_done_i = 1'b0; ovf_vec_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      vec_n++;
      if (busy_o !== 1'b1) begin
         miss_n++; $display("FAIL reset_prescan_busy: got %b, need 1", busy_o);
      end
      model_flags = 4'b1010;
      wr_q.delete();
      dc = done_cnt;
      #2 rst_ni = 1'b0;
      #1;
      got = {flags_we_o, flags_wdata_o, busy_o, done_o, ovf_any_o, ovf_cnt_o, first_idx_o, irq_o};
      vec_n++;
      if (got !== '0) begin
         miss_n++; $display("FAIL reset_midscan: got %h, need 0", got);
      end
      @(posedge clk_i); #1 rst_ni = 1'b1;
      repeat (6) @(posedge clk_i);
      #1;
      vec_n++;
      if ({wr_q.size(), busy_o, done_cnt} !== {32'd0, 1'b0, dc}) begin
         miss_n++;
         $display("FAIL reset_abort: writes %0d busy %b dones %0d, need 0 0 %0d",
                  wr_q.size(), busy_o, done_cnt, dc);
      end
   endtask

   task automatic test_runs(input logic a, input logic [N-1:0] v, input string name);
      exp_t e;
      obs_t o;
      sb.push_back(predict(a, v));
      model_flags = a ? (model_flags | v) : v;
      do_run(a, v, 1, 0, o);
      e = sb.pop_front();
      vec_n++;
      if ({o.cnt, o.idx, o.any, o.lat, o.done_next, o.cleared} !==
          {e.cnt, e.idx, e.any, 8'd7, 1'b0, 1'b1}) begin
         miss_n++;
         $display("FAIL %s_summary: cnt %0d idx %0d any %b lat %0d dn %b clr %b, need %0d %0d %b 7 0 1",
                  name, o.cnt, o.idx, o.any, o.lat, o.done_next, o.cleared,
                  e.cnt, e.idx, e.any);
      end
      vec_n++;
      if (a ? (wr_q.size() != 1 || wr_q[0] !== e.wdata)
            : (wr_q.size() != 2 || wr_q[0] !== '0 || wr_q[1] !== e.wdata)) begin
         miss_n++;
         $display("FAIL %s_writes: %0d writes, last %b, need %0d ending %b", name,
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : '0,
                  a ? 1 : 2, e.wdata);
      end
   endtask

   task automatic test_hold;
      repeat (3) @(posedge clk_i);
      #1;
      vec_n++;
      if ({ovf_cnt_o, first_idx_o, ovf_any_o, busy_o} !== {3'd2, 2'd1, 1'b1, 1'b0}) begin
         miss_n++;
         $display("FAIL summary_hold: cnt %0d idx %0d any %b busy %b, need 2 1 1 0",
                  ovf_cnt_o, first_idx_o, ovf_any_o, busy_o);
      end
   endtask

   task automatic test_ignore;
      exp_t e;
      obs_t o;
      int   dc;
      int   k;
      dc = done_cnt;
      wr_q.delete();
      @(posedge clk_i); #1 matmul_done_i = 1'b1; ovf_vec_i = 4'b1111;
      @(posedge clk_i); #1;
      vec_n++;
      if (busy_o !== 1'b0) begin
         miss_n++; $display("FAIL ign_idle_done: busy %b, need 0", busy_o);
      end
      start_i = 1'b1; accum_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; accum_i = 1'b0; matmul_done_i = 1'b0; ovf_vec_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      vec_n++;
      if ({busy_o, wr_q.size(), done_cnt} !== {1'b1, 32'd0, dc}) begin
         miss_n++;
         $display("FAIL ign_start_done: busy %b writes %0d dones %0d, need 1 0 %0d",
                  busy_o, wr_q.size(), done_cnt, dc);
      end
      sb.push_back(predict(1'b1, 4'b0000));
      matmul_done_i = 1'b1;
      @(posedge clk_i); #1 matmul_done_i = 1'b0;
      k = 0;
      while (!done_o && k < 40) begin
         @(posedge clk_i); #1 k++;
      end
      e = sb.pop_front();
      vec_n++;
      if ({ovf_cnt_o, first_idx_o, done_o} !== {e.cnt, e.idx, 1'b1}) begin
         miss_n++;
         $display("FAIL ign_first_run: cnt %0d idx %0d done %b, need %0d %0d 1",
                  ovf_cnt_o, first_idx_o, done_o, e.cnt, e.idx);
      end
      // Second run: start_i pulsed in RUN, matmul_done_i held for three cycles.
      dc = done_cnt + 1;
      sb.push_back(predict(1'b1, 4'b0100));
      model_flags = model_flags | 4'b0100;
      do_run(1'b1, 4'b0100, 3, 1, o);
      e = sb.pop_front();
      repeat (12) @(posedge clk_i);
      #1;
      vec_n++;
      if ({o.cnt, o.idx, o.lat, done_cnt, busy_o} !== {e.cnt, e.idx, 8'd7, dc + 1, 1'b0}) begin
         miss_n++;
         $display("FAIL ign_busy_start: cnt %0d idx %0d lat %0d dones %0d busy %b, need %0d %0d 7 %0d 0",
                  o.cnt, o.idx, o.lat, done_cnt, busy_o, e.cnt, e.idx, dc + 1);
      end
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] v;
      logic         a;
      for (int i = 0; i < 8; i++) begin
         v = N'($urandom_range(0, (1 << N) - 1));
         a = 1'($urandom_range(0, 1));
         if (i == 0) v = 4'b1111;
         test_runs(a, v, "b2b");
      end
   endtask

   task automatic test_irq;
      obs_t o;
      @(posedge clk_i); #1 irq_clr_i = 1'b1;
      @(posedge clk_i); #1 irq_clr_i = 1'b0;
      vec_n++;
      if (irq_o !== 1'b0) begin
         miss_n++; $display("FAIL irq_clear0: got %b, need 0", irq_o);
      end
      model_flags = 4'b1010;
      do_run(1'b0, 4'b1010, 1, 0, o);
`ifdef FLAGS_CTRL_IRQ_EN
      vec_n++;
      if (irq_o !== 1'b1) begin
         miss_n++; $display("FAIL irq_set: got %b, need 1", irq_o);
      end
      model_flags = '0;
      do_run(1'b0, 4'b0000, 1, 0, o);
      vec_n++;
      if ({o.irq, irq_o} !== 2'b11) begin
         miss_n++; $display("FAIL irq_sticky: got %b, need 11", {o.irq, irq_o});
      end
      @(posedge clk_i); #1 irq_clr_i = 1'b1;
      @(posedge clk_i); #1 irq_clr_i = 1'b0;
      do_run(1'b0, 4'b0000, 1, 0, o);
      vec_n++;
      if (irq_o !== 1'b0) begin
         miss_n++; $display("FAIL irq_zero_run: got %b, need 0", irq_o);
      end
      // Clear held across the whole run must beat the DONE-cycle set.
      irq_clr_i = 1'b1;
      model_flags = 4'b0001;
      do_run(1'b0, 4'b0001, 1, 0, o);
      irq_clr_i = 1'b0;
      vec_n++;
      if (irq_o !== 1'b0) begin
         miss_n++; $display("FAIL irq_clr_wins: got %b, need 0", irq_o);
      end
`else
      vec_n++;
      if ({o.irq, irq_o} !== 2'b00) begin
         miss_n++; $display("FAIL irq_disabled: got %b, need 00", {o.irq, irq_o});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_runs(1'b0, 4'b0000, "zero");
      test_runs(1'b0, 4'b1010, "basic");
      test_hold();
      test_runs(1'b1, 4'b0101, "accum");
      test_ignore();
      test_back_to_back();
      test_irq();
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
